// File: rtl/dual_frame_compare.sv
// Pairs one frame from each CRC-checked channel, waits a bounded time for the late one,
// then reports a compare status, an XOR diff mask and saturating error statistics.
module dual_frame_compare #(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              aDone,
    input  logic              aCrcOk,
    input  logic [DATA_W-1:0] aData,
    input  logic              bDone,
    input  logic              bCrcOk,
    input  logic [DATA_W-1:0] bData,
    output logic              resValid,
    output logic [2:0]        status,
    output logic [DATA_W-1:0] diffMask,
    output logic              overrun,
    output logic [CNT_W-1:0]  frameCnt,
    output logic [CNT_W-1:0]  errCnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_A  = 3'd1;
    localparam logic [2:0] S_WAIT_B  = 3'd2;
    localparam logic [2:0] S_COMPARE = 3'd3;
    localparam logic [2:0] S_REPORT  = 3'd4;

    localparam logic [2:0] ST_MATCH     = 3'd0;
    localparam logic [2:0] ST_MISMATCH  = 3'd1;
    localparam logic [2:0] ST_A_CRC     = 3'd2;
    localparam logic [2:0] ST_B_CRC     = 3'd3;
    localparam logic [2:0] ST_BOTH_CRC  = 3'd4;
    localparam logic [2:0] ST_A_MISSING = 3'd5;
    localparam logic [2:0] ST_B_MISSING = 3'd6;

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    function automatic logic [2:0] classify(input logic a_ok, input logic b_ok, input logic same);
        logic [2:0] code;
        if (!a_ok && !b_ok) begin
            code = ST_BOTH_CRC;
        end else if (!a_ok) begin
            code = ST_A_CRC;
        end else if (!b_ok) begin
            code = ST_B_CRC;
        end else if (same) begin
            code = ST_MATCH;
        end else begin
            code = ST_MISMATCH;
        end
        return code;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic [2:0]        state_q,      state_d;
    logic [CNT_W-1:0]  timer_q,      timer_d;
    logic [DATA_W-1:0] a_data_q,     a_data_d;
    logic [DATA_W-1:0] b_data_q,     b_data_d;
    logic              a_ok_q,       a_ok_d;
    logic              b_ok_q,       b_ok_d;
    logic              a_pend_q,     a_pend_d;
    logic              b_pend_q,     b_pend_d;
    logic [2:0]        res_status_q, res_status_d;
    logic [DATA_W-1:0] res_diff_q,   res_diff_d;
    logic              res_valid_q,  res_valid_d;
    logic [2:0]        status_q,     status_d;
    logic [DATA_W-1:0] diff_mask_q,  diff_mask_d;
    logic              overrun_q,    overrun_d;
    logic [CNT_W-1:0]  frame_cnt_q,  frame_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q,    err_cnt_d;

    logic              eff_a_s;
    logic              eff_b_s;
    logic [2:0]        route_state_s;
    logic [2:0]        cmp_status_s;

    // Next-state, latch capture and result computation
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        a_data_d      = a_data_q;
        b_data_d      = b_data_q;
        a_ok_d        = a_ok_q;
        b_ok_d        = b_ok_q;
        a_pend_d      = 1'b0;
        b_pend_d      = 1'b0;
        res_status_d  = res_status_q;
        res_diff_d    = res_diff_q;
        res_valid_d   = 1'b0;
        status_d      = status_q;
        diff_mask_d   = diff_mask_q;
        overrun_d     = overrun_q;
        frame_cnt_d   = frame_cnt_q;
        err_cnt_d     = err_cnt_q;

        if (aDone) begin
            a_data_d = aData;
            a_ok_d   = aCrcOk;
        end else begin
            a_data_d = a_data_q;
        end
        if (bDone) begin
            b_data_d = bData;
            b_ok_d   = bCrcOk;
        end else begin
            b_data_d = b_data_q;
        end

        // Pending flags only survive COMPARE -> REPORT, so they are zero elsewhere
        eff_a_s = aDone | a_pend_q;
        eff_b_s = bDone | b_pend_q;
        if (eff_a_s && eff_b_s) begin
            route_state_s = S_COMPARE;
        end else if (eff_a_s) begin
            route_state_s = S_WAIT_B;
        end else if (eff_b_s) begin
            route_state_s = S_WAIT_A;
        end else begin
            route_state_s = S_IDLE;
        end

        cmp_status_s = classify(a_ok_q, b_ok_q, a_data_q == b_data_q);

        case (state_q)
            S_IDLE: begin
                state_d = route_state_s;
                timer_d = CNT_ZERO;
            end
            S_WAIT_B: begin
                if (bDone) begin
                    state_d = S_COMPARE;
                end else if (aDone) begin
                    timer_d = CNT_ZERO;
                end else if (timer_q == TMO_LAST) begin
                    state_d      = S_REPORT;
                    res_status_d = ST_B_MISSING;
                    res_diff_d   = DATA_ZERO;
                end else begin
                    timer_d = timer_q + CNT_ONE;
                end
                if (aDone) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end
            S_WAIT_A: begin
                if (aDone) begin
                    state_d = S_COMPARE;
                end else if (bDone) begin
                    timer_d = CNT_ZERO;
                end else if (timer_q == TMO_LAST) begin
                    state_d      = S_REPORT;
                    res_status_d = ST_A_MISSING;
                    res_diff_d   = DATA_ZERO;
                end else begin
                    timer_d = timer_q + CNT_ONE;
                end
                if (bDone) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end
            S_COMPARE: begin
                state_d      = S_REPORT;
                res_status_d = cmp_status_s;
                if (cmp_status_s == ST_MATCH || cmp_status_s == ST_MISMATCH) begin
                    res_diff_d = a_data_q ^ b_data_q;
                end else begin
                    res_diff_d = DATA_ZERO;
                end
                a_pend_d = aDone;
                b_pend_d = bDone;
            end
            S_REPORT: begin
                res_valid_d = 1'b1;
                status_d    = res_status_q;
                diff_mask_d = res_diff_q;
                frame_cnt_d = sat_inc(frame_cnt_q);
                if (res_status_q != ST_MATCH) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                end else begin
                    err_cnt_d = err_cnt_q;
                end
                if ((a_pend_q && aDone) || (b_pend_q && bDone)) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                state_d = route_state_s;
                timer_d = CNT_ZERO;
            end
            default: begin
                state_d = S_IDLE;
                timer_d = CNT_ZERO;
            end
        endcase
    end

    // State and output registers, updated on the falling edge like the CRC stages
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            timer_q      <= CNT_ZERO;
            a_data_q     <= DATA_ZERO;
            b_data_q     <= DATA_ZERO;
            a_ok_q       <= 1'b0;
            b_ok_q       <= 1'b0;
            a_pend_q     <= 1'b0;
            b_pend_q     <= 1'b0;
            res_status_q <= ST_MATCH;
            res_diff_q   <= DATA_ZERO;
            res_valid_q  <= 1'b0;
            status_q     <= ST_MATCH;
            diff_mask_q  <= DATA_ZERO;
            overrun_q    <= 1'b0;
            frame_cnt_q  <= CNT_ZERO;
            err_cnt_q    <= CNT_ZERO;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            a_data_q     <= a_data_d;
            b_data_q     <= b_data_d;
            a_ok_q       <= a_ok_d;
            b_ok_q       <= b_ok_d;
            a_pend_q     <= a_pend_d;
            b_pend_q     <= b_pend_d;
            res_status_q <= res_status_d;
            res_diff_q   <= res_diff_d;
            res_valid_q  <= res_valid_d;
            status_q     <= status_d;
            diff_mask_q  <= diff_mask_d;
            overrun_q    <= overrun_d;
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign resValid = res_valid_q;
    assign status   = status_q;
    assign diffMask = diff_mask_q;
    assign overrun  = overrun_q;
    assign frameCnt = frame_cnt_q;
    assign errCnt   = err_cnt_q;

endmodule
